// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the pipeline: opcodes, 11-bit control-vector
// layout and values, hazard-vector bit positions, forwarding and halt-state types.
package cpu_ctrl_pkg;

    localparam int CV_W = 11;
    localparam int HV_W = 10;
    localparam int RA_W = 4;

    localparam int CV_REGWRITE = 10;
    localparam int CV_ALUSUB   = 9;
    localparam int CV_BRANCH   = 8;
    localparam int CV_MEMREAD  = 7;
    localparam int CV_IMMSEL   = 6;
    localparam int CV_MEMWRITE = 5;
    localparam int CV_SPARE    = 4;
    localparam int CV_MEMTOREG = 3;
    localparam int CV_MOVSEL   = 2;
    localparam int CV_FPOP     = 1;
    localparam int CV_HALT     = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_ADDI = 4'h3,
        OP_LW   = 4'h4,
        OP_SW   = 4'h5,
        OP_JMPZ = 4'h6,
        OP_MOV  = 4'h7,
        OP_STOP = 4'hF
    } opcode_e;

    localparam logic [CV_W-1:0] CVV_NOP  = 11'h000;
    localparam logic [CV_W-1:0] CVV_ADD  = 11'h400;
    localparam logic [CV_W-1:0] CVV_SUB  = 11'h600;
    localparam logic [CV_W-1:0] CVV_ADDI = 11'h440;
    localparam logic [CV_W-1:0] CVV_LW   = 11'h4C8;
    localparam logic [CV_W-1:0] CVV_SW   = 11'h060;
    localparam logic [CV_W-1:0] CVV_JMPZ = 11'h300;
    localparam logic [CV_W-1:0] CVV_MOV  = 11'h404;
    localparam logic [CV_W-1:0] CVV_STOP = 11'h001;

    // Hazard vector: {alu_src1, alu_src2, mem_src, flushEX_MEM, flushIF_ID, flushIDEX, pcstall, IFIDstall}
    localparam int HV_ALU_SRC1    = 8;
    localparam int HV_ALU_SRC2    = 6;
    localparam int HV_MEM_SRC     = 5;
    localparam int HV_FLUSH_EXMEM = 4;
    localparam int HV_FLUSH_IFID  = 3;
    localparam int HV_FLUSH_IDEX  = 2;
    localparam int HV_PCSTALL     = 1;
    localparam int HV_IFIDSTALL   = 0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    function automatic logic [CV_W-1:0] cv_of(input opcode_e op);
        case (op)
            OP_ADD:  return CVV_ADD;
            OP_SUB:  return CVV_SUB;
            OP_ADDI: return CVV_ADDI;
            OP_LW:   return CVV_LW;
            OP_SW:   return CVV_SW;
            OP_JMPZ: return CVV_JMPZ;
            OP_MOV:  return CVV_MOV;
            OP_STOP: return CVV_STOP;
            default: return CVV_NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode-side inputs and hazard/pipeline outputs of the hazard unit.
interface pipe_hazard_unit_if;
    import cpu_ctrl_pkg::*;

    logic [CV_W-1:0] id_cv_i;
    logic [RA_W-1:0] id_rd_i;
    logic [RA_W-1:0] id_rs_i;
    logic [RA_W-1:0] id_rt_i;
    logic            ex_zero_i;
    logic [HV_W-1:0] hazard_control_vector_o;
    logic [CV_W-1:0] ex_cv_o;
    logic [CV_W-1:0] mem_cv_o;
    logic [CV_W-1:0] wb_cv_o;
    logic [RA_W-1:0] wb_rd_o;
    logic            halted_o;

    modport master (
        output id_cv_i, id_rd_i, id_rs_i, id_rt_i, ex_zero_i,
        input  hazard_control_vector_o, ex_cv_o, mem_cv_o, wb_cv_o, wb_rd_o, halted_o
    );

    modport slave (
        input  id_cv_i, id_rd_i, id_rs_i, id_rt_i, ex_zero_i,
        output hazard_control_vector_o, ex_cv_o, mem_cv_o, wb_cv_o, wb_rd_o, halted_o
    );

endinterface

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// Forwarding source select for one EX operand; the MEM result wins over WB, R0 never forwards.
module fwd_sel
    import cpu_ctrl_pkg::*;
(
    input  logic [RA_W-1:0] src_i,
    input  logic            mem_regwrite_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            wb_regwrite_i,
    input  logic [RA_W-1:0] wb_rd_i,
    output fwd_e            sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ID/EX, EX/MEM, MEM/WB control registers with forwarding, load-use stall,
// branch flush and a halt drain sequencer.
module pipe_hazard_unit
    import cpu_ctrl_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_unit_if.slave bus
);

    logic [CV_W-1:0] ex_cv_q, ex_cv_d, mem_cv_q, mem_cv_d, wb_cv_q, wb_cv_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [RA_W-1:0] mem_rd_q, mem_rd_d, mem_rt_q, mem_rt_d, wb_rd_q, wb_rd_d;
    halt_state_e     state_q, state_d;
    logic            halted_q, halted_d;

    logic [RA_W-1:0] ex_src [2];
    fwd_e            fwd_w  [2];
    logic [HV_W-1:0] hcv;
    logic            rs_used, rt_used, load_use, branch_taken, mem_src;

    assign ex_src[0] = ex_rs_q;
    assign ex_src[1] = ex_rt_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .src_i          (ex_src[gi]),
                .mem_regwrite_i (mem_cv_q[CV_REGWRITE]),
                .mem_rd_i       (mem_rd_q),
                .wb_regwrite_i  (wb_cv_q[CV_REGWRITE]),
                .wb_rd_i        (wb_rd_q),
                .sel_o          (fwd_w[gi])
            );
        end
    endgenerate

    // Store data is not an rt "use": the value is picked up late through mem_src.
    always_comb begin
        rs_used      = (bus.id_cv_i != '0) && !bus.id_cv_i[CV_HALT] && !bus.id_cv_i[CV_MOVSEL];
        rt_used      = bus.id_cv_i[CV_REGWRITE] && !bus.id_cv_i[CV_IMMSEL];
        load_use     = ex_cv_q[CV_MEMREAD] && (ex_rd_q != '0) &&
                       (((bus.id_rs_i == ex_rd_q) && rs_used) ||
                        ((bus.id_rt_i == ex_rd_q) && rt_used));
        branch_taken = ex_cv_q[CV_BRANCH] && bus.ex_zero_i;
        mem_src      = mem_cv_q[CV_MEMWRITE] && wb_cv_q[CV_REGWRITE] &&
                       (wb_rd_q != '0) && (wb_rd_q == mem_rt_q);

        hcv                    = '0;
        hcv[HV_ALU_SRC1 +: 2]  = fwd_w[0];
        hcv[HV_ALU_SRC2 +: 2]  = ex_cv_q[CV_IMMSEL] ? FWD_NONE : fwd_w[1];
        hcv[HV_MEM_SRC]        = mem_src;
        // Draining a halt dominates everything; a taken branch cancels a pending stall.
        if (state_q != ST_RUN) begin
            hcv[HV_FLUSH_EXMEM] = 1'b1;
            hcv[HV_FLUSH_IDEX]  = 1'b1;
            hcv[HV_PCSTALL]     = 1'b1;
            hcv[HV_IFIDSTALL]   = 1'b1;
        end else if (branch_taken) begin
            hcv[HV_FLUSH_IFID]  = 1'b1;
            hcv[HV_FLUSH_IDEX]  = 1'b1;
        end else if (load_use) begin
            hcv[HV_FLUSH_IDEX]  = 1'b1;
            hcv[HV_PCSTALL]     = 1'b1;
            hcv[HV_IFIDSTALL]   = 1'b1;
        end
    end

    always_comb begin
        ex_cv_d  = hcv[HV_FLUSH_IDEX]  ? '0 : bus.id_cv_i;
        ex_rd_d  = hcv[HV_FLUSH_IDEX]  ? '0 : bus.id_rd_i;
        ex_rs_d  = hcv[HV_FLUSH_IDEX]  ? '0 : bus.id_rs_i;
        ex_rt_d  = hcv[HV_FLUSH_IDEX]  ? '0 : bus.id_rt_i;
        mem_cv_d = hcv[HV_FLUSH_EXMEM] ? '0 : ex_cv_q;
        mem_rd_d = hcv[HV_FLUSH_EXMEM] ? '0 : ex_rd_q;
        mem_rt_d = hcv[HV_FLUSH_EXMEM] ? '0 : ex_rt_q;
        wb_cv_d  = mem_cv_q;
        wb_rd_d  = mem_rd_q;

        state_d = state_q;
        case (state_q)
            ST_RUN:    if (ex_cv_q[CV_HALT])  state_d = ST_DRAIN;
            ST_DRAIN:  if (mem_cv_q[CV_HALT]) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cv_q  <= '0;
            ex_rd_q  <= '0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
            mem_cv_q <= '0;
            mem_rd_q <= '0;
            mem_rt_q <= '0;
            wb_cv_q  <= '0;
            wb_rd_q  <= '0;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            ex_cv_q  <= ex_cv_d;
            ex_rd_q  <= ex_rd_d;
            ex_rs_q  <= ex_rs_d;
            ex_rt_q  <= ex_rt_d;
            mem_cv_q <= mem_cv_d;
            mem_rd_q <= mem_rd_d;
            mem_rt_q <= mem_rt_d;
            wb_cv_q  <= wb_cv_d;
            wb_rd_q  <= wb_rd_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign bus.hazard_control_vector_o = hcv;
    assign bus.ex_cv_o  = ex_cv_q;
    assign bus.mem_cv_o = mem_cv_q;
    assign bus.wb_cv_o  = wb_cv_q;
    assign bus.wb_rd_o  = wb_rd_q;
    assign bus.halted_o = halted_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed instruction sequences through the hazard unit with hand-computed
// hazard vectors checked in the EX/MEM/WB cycle of interest.
module tb_pipe_hazard_unit;
    import cpu_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_unit_if bus ();

    pipe_hazard_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic [CV_W-1:0] cv, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [3:0] rt, input logic z);
        bus.id_cv_i   = cv;
        bus.id_rd_i   = rd;
        bus.id_rs_i   = rs;
        bus.id_rt_i   = rt;
        bus.ex_zero_i = z;
    endtask

    // One ID slot: present after the edge, settle, then print the cycle.
    task automatic cyc(input logic [CV_W-1:0] cv, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt, input logic z);
        @(posedge clk);
        #1;
        set_id(cv, rd, rs, rt, z);
        #3;
        $display("t=%0t id_cv=%h rd=%0d rs=%0d rt=%0d z=%b | ex=%h mem=%h wb=%h wb_rd=%0d hcv=%h halted=%b",
                 $time, cv, rd, rs, rt, z, bus.ex_cv_o, bus.mem_cv_o, bus.wb_cv_o,
                 bus.wb_rd_o, bus.hazard_control_vector_o, bus.halted_o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_id(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL reset_hcv got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        total++; if (bus.ex_cv_o !== 11'h000) begin bad++; $display("FAIL reset_ex_cv got=%h want=%h", bus.ex_cv_o, 11'h000); end
        total++; if (bus.wb_cv_o !== 11'h000 || bus.wb_rd_o !== 4'd0) begin bad++; $display("FAIL reset_wb got=%h/%0d want=000/0", bus.wb_cv_o, bus.wb_rd_o); end
        total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", bus.halted_o); end
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        total++; if (bus.ex_cv_o !== 11'h000) begin bad++; $display("FAIL adv_ex_early got=%h want=%h", bus.ex_cv_o, 11'h000); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.ex_cv_o !== 11'h4C8) begin bad++; $display("FAIL adv_ex got=%h want=%h", bus.ex_cv_o, 11'h4C8); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.mem_cv_o !== 11'h4C8) begin bad++; $display("FAIL adv_mem got=%h want=%h", bus.mem_cv_o, 11'h4C8); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.wb_cv_o !== 11'h4C8 || bus.wb_rd_o !== 4'd2) begin bad++; $display("FAIL adv_wb got=%h/%0d want=4c8/2", bus.wb_cv_o, bus.wb_rd_o); end
    endtask

    task automatic test_fwd_mem();
        do_reset();
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd4, 4'd3, 4'd5, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h100) begin bad++; $display("FAIL fwd_mem_src1 got=%h want=%h", bus.hazard_control_vector_o, 10'h100); end
        do_reset();
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd4, 4'd5, 4'd3, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h040) begin bad++; $display("FAIL fwd_mem_src2 got=%h want=%h", bus.hazard_control_vector_o, 10'h040); end
        do_reset();
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_SUB, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd4, 4'd3, 4'd3, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h140) begin bad++; $display("FAIL fwd_mem_priority got=%h want=%h", bus.hazard_control_vector_o, 10'h140); end
        do_reset();
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADDI, 4'd4, 4'd3, 4'd3, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h100) begin bad++; $display("FAIL fwd_imm_mask got=%h want=%h", bus.hazard_control_vector_o, 10'h100); end
        do_reset();
        cyc(CVV_ADD, 4'd0, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd4, 4'd0, 4'd0, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL fwd_r0 got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
    endtask

    task automatic test_fwd_wb();
        do_reset();
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd4, 4'd3, 4'd5, 1'b0);
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h200) begin bad++; $display("FAIL fwd_wb_src1 got=%h want=%h", bus.hazard_control_vector_o, 10'h200); end
        total++; if (bus.wb_rd_o !== 4'd3 || bus.wb_cv_o !== 11'h400) begin bad++; $display("FAIL fwd_wb_regs got=%h/%0d want=400/3", bus.wb_cv_o, bus.wb_rd_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd6, 4'd2, 4'd1, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h007) begin bad++; $display("FAIL lu_stall got=%h want=%h", bus.hazard_control_vector_o, 10'h007); end
        cyc(CVV_ADD, 4'd6, 4'd2, 4'd1, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL lu_one_cycle got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        total++; if (bus.ex_cv_o !== 11'h000) begin bad++; $display("FAIL lu_bubble got=%h want=%h", bus.ex_cv_o, 11'h000); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h200) begin bad++; $display("FAIL lu_fwd_wb got=%h want=%h", bus.hazard_control_vector_o, 10'h200); end
        total++; if (bus.ex_cv_o !== 11'h400) begin bad++; $display("FAIL lu_consumer_ex got=%h want=%h", bus.ex_cv_o, 11'h400); end
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd6, 4'd1, 4'd2, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h007) begin bad++; $display("FAIL lu_rt got=%h want=%h", bus.hazard_control_vector_o, 10'h007); end
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_MOV, 4'd5, 4'd2, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL lu_mov_no_rs got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADDI, 4'd6, 4'd1, 4'd2, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL lu_imm_no_rt got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        do_reset();
        cyc(CVV_LW, 4'd0, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd6, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL lu_r0 got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
    endtask

    task automatic test_store_fwd();
        do_reset();
        cyc(CVV_LW, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_SW, 4'd0, 4'd1, 4'd2, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL sw_no_stall got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL sw_ex_imm got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h020) begin bad++; $display("FAIL sw_mem_src got=%h want=%h", bus.hazard_control_vector_o, 10'h020); end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(CVV_JMPZ, 4'd0, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd7, 4'd1, 4'd1, 1'b1);
        total++; if (bus.hazard_control_vector_o !== 10'h00C) begin bad++; $display("FAIL br_taken got=%h want=%h", bus.hazard_control_vector_o, 10'h00C); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.ex_cv_o !== 11'h000 || bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL br_flushed got=%h/%h want=000/000", bus.ex_cv_o, bus.hazard_control_vector_o); end
        do_reset();
        cyc(CVV_JMPZ, 4'd0, 4'd1, 4'd2, 1'b0);
        cyc(CVV_ADD, 4'd7, 4'd1, 4'd1, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL br_not_taken got=%h want=%h", bus.hazard_control_vector_o, 10'h000); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.ex_cv_o !== 11'h400) begin bad++; $display("FAIL br_fallthrough got=%h want=%h", bus.ex_cv_o, 11'h400); end
        do_reset();
        cyc(11'h580, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd6, 4'd2, 4'd1, 1'b1);
        total++; if (bus.hazard_control_vector_o !== 10'h00C) begin bad++; $display("FAIL br_over_lu got=%h want=%h", bus.hazard_control_vector_o, 10'h00C); end
        do_reset();
        cyc(11'h580, 4'd2, 4'd1, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd6, 4'd2, 4'd1, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h007) begin bad++; $display("FAIL br_nt_lu got=%h want=%h", bus.hazard_control_vector_o, 10'h007); end
    endtask

    task automatic test_halt();
        do_reset();
        cyc(CVV_STOP, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(CVV_ADD, 4'd9, 4'd1, 4'd1, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h000 || bus.halted_o !== 1'b0) begin bad++; $display("FAIL halt_ex got=%h/%b want=000/0", bus.hazard_control_vector_o, bus.halted_o); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h017 || bus.halted_o !== 1'b0) begin bad++; $display("FAIL halt_drain got=%h/%b want=017/0", bus.hazard_control_vector_o, bus.halted_o); end
        total++; if (bus.mem_cv_o !== 11'h001) begin bad++; $display("FAIL halt_mem_cv got=%h want=%h", bus.mem_cv_o, 11'h001); end
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h017 || bus.halted_o !== 1'b1) begin bad++; $display("FAIL halt_halted got=%h/%b want=017/1", bus.hazard_control_vector_o, bus.halted_o); end
        total++; if (bus.wb_cv_o !== 11'h001 || bus.mem_cv_o !== 11'h000) begin bad++; $display("FAIL halt_pipe got=%h/%h want=001/000", bus.wb_cv_o, bus.mem_cv_o); end
        cyc(CVV_ADD, 4'd3, 4'd1, 4'd2, 1'b0);
        total++; if (bus.hazard_control_vector_o !== 10'h017 || bus.halted_o !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%h/%b want=017/1", bus.hazard_control_vector_o, bus.halted_o); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.halted_o !== 1'b0 || bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL halt_async_rst got=%b/%h want=0/000", bus.halted_o, bus.hazard_control_vector_o); end
        total++; if (bus.wb_cv_o !== 11'h000 || bus.ex_cv_o !== 11'h000) begin bad++; $display("FAIL halt_rst_regs got=%h/%h want=000/000", bus.wb_cv_o, bus.ex_cv_o); end
        do_reset();
        cyc(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        total++; if (bus.halted_o !== 1'b0 || bus.hazard_control_vector_o !== 10'h000) begin bad++; $display("FAIL halt_after_rst got=%b/%h want=0/000", bus.halted_o, bus.hazard_control_vector_o); end
    endtask

    initial begin
        set_id(CVV_NOP, 4'd0, 4'd0, 4'd0, 1'b0);
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_store_fwd();
        test_branch();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
